// File: rtl/decode_stage.sv
// Decode stage between the fetch queue and rename: decodes one RV32 instruction per cycle
// into a registered uop, with a 1-entry skid buffer for full throughput under backpressure.
module decode_stage #(
    parameter int PC_W    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [31:0]        instr,
    input  logic [PC_W-1:0]    pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [PC_W-1:0]    dec_pc,
    output logic [31:0]        dec_imm,
    output logic [4:0]         dec_rs1,
    output logic [4:0]         dec_rs2,
    output logic [4:0]         dec_rd,
    output logic               dec_use_rs1,
    output logic               dec_use_rs2,
    output logic               dec_wr_rd,
    output logic [1:0]         dec_fu,
    output logic [ALUOP_W-1:0] dec_alu_op,
    output logic [2:0]         dec_funct3,
    output logic               dec_is_store,
    output logic               dec_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] FU_ALU  = 2'b00;
    localparam logic [1:0] FU_BRU  = 2'b01;
    localparam logic [1:0] FU_LSU  = 2'b10;
    localparam logic [1:0] FU_NONE = 2'b11;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLL   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SRL   = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SRA   = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_SLTU  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_PASSB = ALUOP_W'(10);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [31:0]        imm;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic               use_rs1;
        logic               use_rs2;
        logic               wr_rd;
        logic [1:0]         fu;
        logic [ALUOP_W-1:0] alu_op;
        logic [2:0]         funct3;
        logic               is_store;
        logic               illegal;
    } uop_t;

    // Register-register ops select SUB via funct7[5]; immediate ops never do.
    function automatic logic [ALUOP_W-1:0] alu_sel(input logic [2:0] f3, input logic alt,
                                                   input logic reg_op);
        case (f3)
            3'b000:  alu_sel = (reg_op && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [31:0] imm_i, imm_s, imm_b, imm_u;
    uop_t        dec_in;

    assign opcode = instr[6:0];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};

    always_comb begin
        dec_in        = '0;
        dec_in.pc     = pc;
        dec_in.rs1    = instr[19:15];
        dec_in.rs2    = instr[24:20];
        dec_in.rd     = instr[11:7];
        dec_in.funct3 = instr[14:12];
        dec_in.fu     = FU_ALU;
        dec_in.alu_op = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                dec_in.use_rs1 = 1'b1;
                dec_in.use_rs2 = 1'b1;
                dec_in.wr_rd   = 1'b1;
                dec_in.alu_op  = alu_sel(instr[14:12], instr[30], 1'b1);
            end
            OPC_OP_IMM: begin
                dec_in.use_rs1 = 1'b1;
                dec_in.wr_rd   = 1'b1;
                dec_in.imm     = imm_i;
                dec_in.alu_op  = alu_sel(instr[14:12], instr[30], 1'b0);
            end
            OPC_LUI: begin
                dec_in.wr_rd  = 1'b1;
                dec_in.imm    = imm_u;
                dec_in.alu_op = ALU_PASSB;
            end
            OPC_LOAD: begin
                dec_in.use_rs1 = 1'b1;
                dec_in.wr_rd   = 1'b1;
                dec_in.imm     = imm_i;
                dec_in.fu      = FU_LSU;
            end
            OPC_STORE: begin
                dec_in.use_rs1  = 1'b1;
                dec_in.use_rs2  = 1'b1;
                dec_in.imm      = imm_s;
                dec_in.fu       = FU_LSU;
                dec_in.is_store = 1'b1;
            end
            OPC_BRANCH: begin
                dec_in.use_rs1 = 1'b1;
                dec_in.use_rs2 = 1'b1;
                dec_in.imm     = imm_b;
                dec_in.fu      = FU_BRU;
            end
            OPC_JALR: begin
                dec_in.use_rs1 = 1'b1;
                dec_in.wr_rd   = 1'b1;
                dec_in.imm     = imm_i;
                dec_in.fu      = FU_BRU;
            end
            default: begin
                dec_in.illegal = 1'b1;
                dec_in.fu      = FU_NONE;
            end
        endcase
        if (dec_in.rd == 5'd0) dec_in.wr_rd = 1'b0;
    end

    // Handshake: a transfer happens on a rising edge where valid && ready. Producers hold
    // valid and data stable until accepted; instr_ready depends only on registered skid state.
    uop_t out_q, skid_q;
    logic out_valid, skid_valid;
    logic accept, out_load;

    assign instr_ready = !skid_valid;
    assign accept      = instr_valid && instr_ready && !flush;
    assign out_load    = !out_valid || dec_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_load) begin
            // Skid holds the older uop, so it drains before any new input is taken.
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) out_q <= dec_in;
            end
        end else if (accept) begin
            skid_q     <= dec_in;
            skid_valid <= 1'b1;
        end
    end

    assign dec_valid    = out_valid;
    assign dec_pc       = out_q.pc;
    assign dec_imm      = out_q.imm;
    assign dec_rs1      = out_q.rs1;
    assign dec_rs2      = out_q.rs2;
    assign dec_rd       = out_q.rd;
    assign dec_use_rs1  = out_q.use_rs1;
    assign dec_use_rs2  = out_q.use_rs2;
    assign dec_wr_rd    = out_q.wr_rd;
    assign dec_fu       = out_q.fu;
    assign dec_alu_op   = out_q.alu_op;
    assign dec_funct3   = out_q.funct3;
    assign dec_is_store = out_q.is_store;
    assign dec_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode fields, skid ordering,
// flush, throughput and asynchronous reset.
module tb_decode_stage;

    logic        clk, rst_n, flush, instr_valid, instr_ready, dec_valid, dec_ready;
    logic [31:0] instr, pc, dec_pc, dec_imm;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_use_rs1, dec_use_rs2, dec_wr_rd, dec_is_store, dec_illegal;
    logic [1:0]  dec_fu;
    logic [3:0]  dec_alu_op;
    logic [2:0]  dec_funct3;
    logic [10:0] obs_ctrl;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    // {fu, alu_op, wr_rd, use_rs1, use_rs2, is_store, illegal}
    assign obs_ctrl = {dec_fu, dec_alu_op, dec_wr_rd, dec_use_rs1, dec_use_rs2,
                       dec_is_store, dec_illegal};

    decode_stage #(.PC_W(32), .ALUOP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc(pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_imm(dec_imm),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr_rd(dec_wr_rd),
        .dec_fu(dec_fu), .dec_alu_op(dec_alu_op), .dec_funct3(dec_funct3),
        .dec_is_store(dec_is_store), .dec_illegal(dec_illegal)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // driver: present one instruction for exactly one edge, then drop valid
    task automatic issue(input logic [31:0] i, input logic [31:0] p);
        instr_valid = 1'b1;
        instr       = i;
        pc          = p;
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; instr_valid = 1'b0; dec_ready = 1'b0;
        instr = 32'h0; pc = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (dec_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
        tests_run++;
        if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_instr_ready: got %b expected 1", instr_ready); end
        tests_run++;
        if ({dec_pc, dec_imm, dec_rs1, dec_rs2, dec_rd, obs_ctrl, dec_funct3} !== '0) begin
            tests_failed++; $display("FAIL reset_data: got pc=%h imm=%h ctrl=%h expected all zero", dec_pc, dec_imm, obs_ctrl);
        end
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_decode;
        dec_ready = 1'b1;
        // addi x1,x0,-1
        issue(32'hFFF00093, 32'h100);
        tests_run++;
        if ({dec_valid, dec_rd, dec_pc} !== {1'b1, 5'd1, 32'h100}) begin
            tests_failed++; $display("FAIL addi_valid_rd_pc: got %b/%0d/%h expected 1/1/100", dec_valid, dec_rd, dec_pc);
        end
        tests_run++;
        if (dec_imm !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL addi_imm: got %h expected ffffffff", dec_imm); end
        tests_run++;
        if (obs_ctrl !== 11'b00_0000_1_1_0_0_0) begin tests_failed++; $display("FAIL addi_ctrl: got %b expected 00000011000", obs_ctrl); end
        // sw x2,8(x1)
        issue(32'h0020A423, 32'h104);
        tests_run++;
        if ({dec_imm, dec_rs1, dec_rs2} !== {32'h8, 5'd1, 5'd2}) begin
            tests_failed++; $display("FAIL sw_imm_rs: got %h/%0d/%0d expected 8/1/2", dec_imm, dec_rs1, dec_rs2);
        end
        tests_run++;
        if (obs_ctrl !== 11'b10_0000_0_1_1_1_0) begin tests_failed++; $display("FAIL sw_ctrl: got %b expected 10000001110", obs_ctrl); end
        // bne x1,x2,-4
        issue(32'hFE209EE3, 32'h108);
        tests_run++;
        if ({dec_imm, dec_funct3} !== {32'hFFFFFFFC, 3'b001}) begin
            tests_failed++; $display("FAIL bne_imm_f3: got %h/%b expected fffffffc/001", dec_imm, dec_funct3);
        end
        tests_run++;
        if (obs_ctrl !== 11'b01_0000_0_1_1_0_0) begin tests_failed++; $display("FAIL bne_ctrl: got %b expected 01000001100", obs_ctrl); end
        // sub x3,x1,x2
        issue(32'h402081B3, 32'h10C);
        tests_run++;
        if (obs_ctrl !== 11'b00_0001_1_1_1_0_0) begin tests_failed++; $display("FAIL sub_ctrl: got %b expected 00000111100", obs_ctrl); end
        // srai x5,x1,3
        issue(32'h4030D293, 32'h110);
        tests_run++;
        if (obs_ctrl !== 11'b00_0111_1_1_0_0_0) begin tests_failed++; $display("FAIL srai_ctrl: got %b expected 00011111000", obs_ctrl); end
        // lui x7,0x12345
        issue(32'h123453B7, 32'h114);
        tests_run++;
        if ({dec_imm, obs_ctrl} !== {32'h12345000, 11'b00_1010_1_0_0_0_0}) begin
            tests_failed++; $display("FAIL lui: got imm=%h ctrl=%b expected 12345000/00101010000", dec_imm, obs_ctrl);
        end
        // lw x4,-8(x2)
        issue(32'hFF812203, 32'h118);
        tests_run++;
        if ({dec_imm, dec_rs1, obs_ctrl} !== {32'hFFFFFFF8, 5'd2, 11'b10_0000_1_1_0_0_0}) begin
            tests_failed++; $display("FAIL lw: got imm=%h rs1=%0d ctrl=%b expected fffffff8/2/10000011000", dec_imm, dec_rs1, obs_ctrl);
        end
        // jal: illegal
        issue(32'h0000006F, 32'h11C);
        tests_run++;
        if ({dec_valid, dec_imm, obs_ctrl} !== {1'b1, 32'h0, 11'b11_0000_0_0_0_0_1}) begin
            tests_failed++; $display("FAIL jal_illegal: got v=%b imm=%h ctrl=%b expected 1/0/11000000001", dec_valid, dec_imm, obs_ctrl);
        end
        // add x0,x1,x2: rd==x0 suppresses write
        issue(32'h00208033, 32'h120);
        tests_run++;
        if ({dec_wr_rd, dec_use_rs2} !== 2'b01) begin tests_failed++; $display("FAIL add_x0_wr_rd: got wr=%b rs2=%b expected 0/1", dec_wr_rd, dec_use_rs2); end
        @(posedge clk); #1;
        tests_run++;
        if (dec_valid !== 1'b0) begin tests_failed++; $display("FAIL decode_drain: got %b expected 0", dec_valid); end
    endtask

    task automatic test_throughput;
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr_valid = 1'b1;
            instr = 32'h00000013 | (32'(i + 1) << 7);
            pc    = 32'h400 + 32'(4 * i);
            @(posedge clk); #1;
            tests_run++;
            if ({dec_valid, instr_ready, dec_pc, dec_rd} !== {1'b1, 1'b1, 32'h400 + 32'(4 * i), 5'(i + 1)}) begin
                tests_failed++; $display("FAIL throughput_%0d: got v=%b r=%b pc=%h rd=%0d expected 1/1/%h/%0d",
                    i, dec_valid, instr_ready, dec_pc, dec_rd, 32'h400 + 32'(4 * i), i + 1);
            end
        end
        instr_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic accepting;
        exp_q.delete();
        dec_ready = 1'b0;
        instr_valid = 1'b1; instr = 32'h00000513; pc = 32'h200; exp_q.push_back(32'h200);
        @(posedge clk); #1;
        tests_run++;
        if ({dec_valid, instr_ready} !== 2'b11) begin tests_failed++; $display("FAIL b2b_first: got v=%b r=%b expected 1/1", dec_valid, instr_ready); end
        instr = 32'h00000593; pc = 32'h204; exp_q.push_back(32'h204);
        @(posedge clk); #1;
        tests_run++;
        if (instr_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_low: got %b expected 0", instr_ready); end
        instr = 32'h00000613; pc = 32'h208; exp_q.push_back(32'h208);
        @(posedge clk); #1;
        tests_run++;
        if ({instr_ready, dec_pc} !== {1'b0, 32'h200}) begin tests_failed++; $display("FAIL b2b_hold: got r=%b pc=%h expected 0/200", instr_ready, dec_pc); end
        dec_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            accepting = instr_valid && instr_ready;
            if (dec_valid) begin
                tests_run++;
                if (dec_pc !== exp_q[0]) begin tests_failed++; $display("FAIL b2b_order: got pc=%h expected %h", dec_pc, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            @(posedge clk); #1;
            if (accepting) instr_valid = 1'b0;
        end
        tests_run++;
        if ({exp_q.size() == 0, instr_valid, dec_valid} !== 3'b100) begin
            tests_failed++; $display("FAIL b2b_drain: got left=%0d pending=%b v=%b expected 0/0/0", exp_q.size(), instr_valid, dec_valid);
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_flush;
        // output and skid full, flush with a new instruction presented
        dec_ready = 1'b0;
        issue(32'h00000693, 32'h300);
        issue(32'h00000713, 32'h304);
        flush = 1'b1; instr_valid = 1'b1; instr = 32'h00000793; pc = 32'h308;
        @(posedge clk); #1;
        flush = 1'b0; instr_valid = 1'b0;
        tests_run++;
        if ({dec_valid, instr_ready} !== 2'b01) begin tests_failed++; $display("FAIL flush_full: got v=%b r=%b expected 0/1", dec_valid, instr_ready); end
        // output only, flush drops an input that would otherwise be accepted
        issue(32'h00000813, 32'h30C);
        flush = 1'b1; instr_valid = 1'b1; instr = 32'h00000893; pc = 32'h310;
        @(posedge clk); #1;
        flush = 1'b0; instr_valid = 1'b0;
        dec_ready = 1'b1;
        tests_run++;
        if ({dec_valid, instr_ready} !== 2'b01) begin tests_failed++; $display("FAIL flush_drop_input: got v=%b r=%b pc=%h expected 0/1", dec_valid, instr_ready, dec_pc); end
        repeat (3) begin
            @(posedge clk); #1;
            tests_run++;
            if (dec_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_ghost: got v=%b pc=%h expected 0", dec_valid, dec_pc); end
        end
    endtask

    task automatic test_async_reset;
        dec_ready = 1'b0;
        issue(32'h00000913, 32'h500);
        issue(32'h00000993, 32'h504);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({dec_valid, instr_ready} !== 2'b01) begin tests_failed++; $display("FAIL async_reset: got v=%b r=%b expected 0/1", dec_valid, instr_ready); end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({dec_valid, instr_ready} !== 2'b01) begin tests_failed++; $display("FAIL post_reset: got v=%b r=%b expected 0/1", dec_valid, instr_ready); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_throughput();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
